mac_layer_sched: RTL and testbench



---
 rtl/mac_layer_sched_if.sv | 34 +++
 rtl/mac_layer_sched.sv | 153 +++++++++++++++
 tb/tb_mac_layer_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_layer_sched_if.sv
// rtl/mac_layer_sched_if.sv - layer sequencer bus: controller, weight memory, engine and result buffer
interface mac_layer_sched_if #(
    parameter int N_IN = 8,
    parameter int DW   = 16,
    parameter int AW   = 8
);
    logic                 start;
    logic [N_IN*DW-1:0]   in_vec;
    logic                 busy;
    logic                 done;
    logic                 w_rd_en;
    logic [AW-1:0]        w_addr;
    logic [N_IN*DW-1:0]   w_rd_data;
    logic [N_IN*DW-1:0]   eng_in;
    logic [N_IN*DW-1:0]   eng_w;
    logic                 eng_start;
    logic                 eng_ready;
    logic [DW-1:0]        eng_result;
    logic                 res_wr_en;
    logic [AW-1:0]        res_addr;
    logic [DW-1:0]        res_data;

    modport master (
        output start, in_vec, w_rd_data, eng_ready, eng_result,
        input  busy, done, w_rd_en, w_addr, eng_in, eng_w, eng_start,
               res_wr_en, res_addr, res_data
    );

    modport slave (
        input  start, in_vec, w_rd_data, eng_ready, eng_result,
        output busy, done, w_rd_en, w_addr, eng_in, eng_w, eng_start,
               res_wr_en, res_addr, res_data
    );
endinterface

// File: rtl/mac_layer_sched.sv
// rtl/mac_layer_sched.sv - fully connected layer sequencer; MAC_LAYER_SCHED_PERF_CNT_EN adds perf counters
module mac_layer_sched #(
    parameter int N_IN   = 8,
    parameter int DW     = 16,
    parameter int N_OUT  = 4,
    parameter int AW     = 8,
    parameter int W_BASE = 0
) (
    input  logic clk,
    input  logic reset_n,
    mac_layer_sched_if.slave bus
`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [15:0] perf_stall
`endif
);
    localparam int VW = N_IN * DW;
    localparam int RW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_WRITE, S_FIN
    } state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row, row_d;
    logic            last_row;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            w_rd_en_q, w_rd_en_d;
    logic            eng_start_q, eng_start_d;
    logic            res_wr_en_q, res_wr_en_d;
    logic [AW-1:0]   w_addr_q, w_addr_d;
    logic [AW-1:0]   res_addr_q, res_addr_d;
    logic [VW-1:0]   eng_in_q, eng_in_d;
    logic [VW-1:0]   eng_w_q, eng_w_d;
    logic [DW-1:0]   res_data_q, res_data_d;

    // Extra row bit lets row 2^AW-1 be the last without wrapping to 0
    assign last_row = (row == RW'(N_OUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            row         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_rd_en_q   <= 1'b0;
            eng_start_q <= 1'b0;
            res_wr_en_q <= 1'b0;
            w_addr_q    <= '0;
            res_addr_q  <= '0;
            eng_in_q    <= '0;
            eng_w_q     <= '0;
            res_data_q  <= '0;
        end else begin
            state       <= state_d;
            row         <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_rd_en_q   <= w_rd_en_d;
            eng_start_q <= eng_start_d;
            res_wr_en_q <= res_wr_en_d;
            w_addr_q    <= w_addr_d;
            res_addr_q  <= res_addr_d;
            eng_in_q    <= eng_in_d;
            eng_w_q     <= eng_w_d;
            res_data_q  <= res_data_d;
        end
    end

    // Completion is only taken after ready has fallen, so a stale idle ready is never mistaken for done
    always_comb begin
        state_d = state;
        row_d   = row;
        case (state)
            S_IDLE:    if (bus.start) begin
                           state_d = S_FETCH;
                           row_d   = '0;
                       end
            S_FETCH:   state_d = S_LOAD;
            S_LOAD:    state_d = S_ISSUE;
            S_ISSUE:   if (bus.eng_ready)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!bus.eng_ready) state_d = S_WAIT_HI;
            S_WAIT_HI: if (bus.eng_ready)  state_d = S_WRITE;
            S_WRITE:   if (last_row) begin
                           state_d = S_FIN;
                       end else begin
                           state_d = S_FETCH;
                           row_d   = row + RW'(1);
                       end
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d      = (state_d == S_FIN);
        w_rd_en_d   = (state_d == S_FETCH);
        eng_start_d = (state == S_ISSUE) && (state_d == S_WAIT_LO);
        res_wr_en_d = (state_d == S_WRITE);
        w_addr_d    = w_addr_q;
        res_addr_d  = res_addr_q;
        eng_in_d    = eng_in_q;
        eng_w_d     = eng_w_q;
        res_data_d  = res_data_q;
        if (state == S_IDLE && bus.start) eng_in_d = bus.in_vec;
        if (state_d == S_FETCH)           w_addr_d = AW'(W_BASE) + row_d[AW-1:0];
        if (state == S_LOAD)              eng_w_d  = bus.w_rd_data;
        if (state_d == S_WRITE) begin
            res_addr_d = row[AW-1:0];
            res_data_d = bus.eng_result;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.w_rd_en   = w_rd_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.eng_in    = eng_in_q;
    assign bus.eng_w     = eng_w_q;
    assign bus.eng_start = eng_start_q;
    assign bus.res_wr_en = res_wr_en_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;

`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_stall_q;

    // busy is already low in FIN, so the cycle count freezes at done without extra logic
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (state == S_IDLE && bus.start) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_q && perf_cycles_q != '1)
                perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state == S_ISSUE && !bus.eng_ready && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_mac_layer_sched.sv
// tb/tb_mac_layer_sched.sv - layer sequencer bench with engine stubs and a row-result scoreboard
module tb_mac_layer_sched;
    localparam int N_IN = 2, DW = 16, AW = 8, VW = N_IN * DW;
    localparam int A_N_OUT = 4, A_BASE = 'h10, A_LAT = 3;
    localparam int B_N_OUT = 1, B_BASE = 0, B_LAT = 10;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mac_layer_sched_if #(.N_IN(N_IN), .DW(DW), .AW(AW)) a_if ();
    mac_layer_sched_if #(.N_IN(N_IN), .DW(DW), .AW(AW)) b_if ();

`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
    logic [31:0] a_perf_cycles, b_perf_cycles;
    logic [15:0] a_perf_stall, b_perf_stall;
`endif

    mac_layer_sched #(.N_IN(N_IN), .DW(DW), .N_OUT(A_N_OUT), .AW(AW), .W_BASE(A_BASE)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if)
`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
        , .perf_cycles(a_perf_cycles), .perf_stall(a_perf_stall)
`endif
    );

    mac_layer_sched #(.N_IN(N_IN), .DW(DW), .N_OUT(B_N_OUT), .AW(AW), .W_BASE(B_BASE)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b_if)
`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
        , .perf_cycles(b_perf_cycles), .perf_stall(b_perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sign-magnitude dot product with negative results clamped to 0, as the engine does
    function automatic logic [DW-1:0] dot(input logic [VW-1:0] x, input logic [VW-1:0] w);
        int acc;
        acc = 0;
        for (int k = 0; k < N_IN; k++) begin
            int xv, wv;
            xv = int'(x[DW*k +: DW-1]);
            wv = int'(w[DW*k +: DW-1]);
            if (x[DW*k+DW-1]) xv = -xv;
            if (w[DW*k+DW-1]) wv = -wv;
            acc += xv * wv;
        end
        if (acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        return DW'(acc);
    endfunction

    logic [VW-1:0] mem [0:255];

    always @(posedge clk) begin
        a_if.w_rd_data <= a_if.w_rd_en ? mem[a_if.w_addr] : 32'hDEAD_BEEF;
        b_if.w_rd_data <= b_if.w_rd_en ? mem[b_if.w_addr] : 32'hDEAD_BEEF;
    end

    // Engine stubs: ready falls 2 cycles after start is sampled and stays low for LAT cycles
    int a_cnt = 0, b_cnt = 0;
    logic a_block = 1'b0;
    logic [DW-1:0] a_res = '0, b_res = '0;

    always @(posedge clk) begin
        if (a_if.eng_start) begin
            a_cnt <= A_LAT + 2;
            a_res <= dot(a_if.eng_in, a_if.eng_w);
        end else if (a_cnt != 0) a_cnt <= a_cnt - 1;
        if (b_if.eng_start) begin
            b_cnt <= B_LAT + 2;
            b_res <= dot(b_if.eng_in, b_if.eng_w);
        end else if (b_cnt != 0) b_cnt <= b_cnt - 1;
    end

    assign a_if.eng_ready  = !a_block && !(a_cnt != 0 && a_cnt <= A_LAT);
    assign a_if.eng_result = (a_cnt == 0) ? a_res : 16'hBAD0;
    assign b_if.eng_ready  = !(b_cnt != 0 && b_cnt <= B_LAT);
    assign b_if.eng_result = (b_cnt == 0) ? b_res : 16'hBAD0;

    // Model of A: the rows a layer must produce, in order
    wr_t           exp_q[$];
    logic [AW-1:0] fetch_q[$];
    logic [VW-1:0] m_vec = '0;
    logic [AW-1:0] last_fetch = '0;
    wr_t           wr_log[$];
    logic [AW-1:0] fetch_log[$];
    int a_done_cnt = 0, a_start_cnt = 0, a_wr_cnt = 0;
    int b_done_cnt = 0, b_start_cnt = 0, b_wr_cnt = 0, b_busy_cyc = 0;
    wr_t b_last_wr = '0;

    task automatic model_layer_a(input logic [VW-1:0] v);
        wr_t e;
        m_vec = v;
        for (int r = 0; r < A_N_OUT; r++) begin
            e.addr = AW'(r);
            e.data = dot(v, mem[A_BASE + r]);
            exp_q.push_back(e);
            fetch_q.push_back(AW'(A_BASE + r));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("busy", a_if.busy, exp_q.size() != 0);
            if (a_if.w_rd_en) begin
                fetch_log.push_back(a_if.w_addr);
                last_fetch = a_if.w_addr;
                check("fetch_expected", fetch_q.size() != 0, 1);
                if (fetch_q.size() != 0) check("w_addr", a_if.w_addr, fetch_q.pop_front());
            end
            if (a_if.eng_start) begin
                a_start_cnt++;
                check("eng_w", a_if.eng_w, mem[last_fetch]);
                check("eng_in", a_if.eng_in, m_vec);
            end
            if (a_if.res_wr_en) begin
                wr_t got;
                got.addr = a_if.res_addr;
                got.data = a_if.res_data;
                a_wr_cnt++;
                wr_log.push_back(got);
                check("eng_w_stable", a_if.eng_w, mem[last_fetch]);
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("res_wr", got, exp_q.pop_front());
            end
            if (a_if.done) begin
                a_done_cnt++;
                check("done_rows_left", exp_q.size(), 0);
            end
            if (b_if.busy) b_busy_cyc++;
            if (b_if.eng_start) b_start_cnt++;
            if (b_if.done) b_done_cnt++;
            if (b_if.res_wr_en) begin
                b_wr_cnt++;
                b_last_wr.addr = b_if.res_addr;
                b_last_wr.data = b_if.res_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_a(input logic [VW-1:0] v, input bit push);
        a_if.start  = 1'b1;
        a_if.in_vec = v;
        step(1);
        a_if.start = 1'b0;
        if (push) model_layer_a(v);
    endtask

    task automatic wait_done(input bit sel_b, input int base, input int max_cyc);
        int n;
        n = 0;
        while ((sel_b ? b_done_cnt : a_done_cnt) == base && n < max_cyc) begin
            step(1);
            n++;
        end
        check(sel_b ? "b_done_seen" : "a_done_seen", (sel_b ? b_done_cnt : a_done_cnt) != base, 1);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_ctl"}, {a_if.busy, a_if.done, a_if.w_rd_en, a_if.eng_start, a_if.res_wr_en}, 0);
        check({tag, "_addr_data"}, {a_if.w_addr, a_if.res_addr, a_if.res_data}, 0);
        check({tag, "_eng_in"}, a_if.eng_in, 0);
        check({tag, "_eng_w"}, a_if.eng_w, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, s0, w0, n, b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem['h10] = {16'd1, 16'd4};
        mem['h11] = {16'd0, 16'd0};
        mem['h12] = {16'd5, 16'h8001};
        mem['h13] = {16'd2, 16'd7};
        mem['h00] = {16'd6, 16'd5};
        a_if.start = 1'b0; a_if.in_vec = '0;
        b_if.start = 1'b0; b_if.in_vec = '0;

        reset_n = 1'b0;
        step(3);
        check_zero_a("reset");
        check("reset_b_ctl", {b_if.busy, b_if.done, b_if.w_rd_en, b_if.eng_start, b_if.res_wr_en}, 0);
        reset_n = 1'b1;
        step(2);

        // Basic layer with an extra start during WAIT_HI of row 0
        wr_log.delete(); fetch_log.delete();
        d0 = a_done_cnt; s0 = a_start_cnt;
        start_a({16'd3, 16'd2}, 1'b1);
        n = 0;
        while (!(a_start_cnt > s0 && !a_if.eng_ready) && n < 100) begin step(1); n++; end
        check("l1_reach_wait", a_start_cnt > s0 && !a_if.eng_ready, 1);
        step(1);
        start_a({16'd9, 16'd9}, 1'b0);
        wait_done(1'b0, d0, 300);
        step(3);
        check("l1_done_once", a_done_cnt - d0, 1);
        check("l1_eng_starts", a_start_cnt - s0, 4);
        check("l1_busy_after", a_if.busy, 0);
        check("l1_wr_count", wr_log.size(), 4);
        if (wr_log.size() >= 2) begin
            check("l1_wr0", wr_log[0], {8'h00, 16'd11});
            check("l1_wr1", wr_log[1], {8'h01, 16'd0});
        end
        check("l1_fetch_count", fetch_log.size(), 4);
        if (fetch_log.size() >= 2) begin
            check("l1_fetch0", fetch_log[0], 8'h10);
            check("l1_fetch1", fetch_log[1], 8'h11);
        end

        // Engine busy for the first 5 ISSUE cycles of row 0
        d0 = a_done_cnt; s0 = a_start_cnt;
        start_a({16'h8001, 16'd4}, 1'b1);
        check("l2_fetch_now", a_if.w_rd_en, 1);
        a_block = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("l2_no_issue", a_if.eng_start, 0);
        end
        a_block = 1'b0;
        step(2);
        check("l2_issue_after_ready", a_start_cnt - s0, 1);
        wait_done(1'b0, d0, 300);
        step(3);
        check("l2_done_once", a_done_cnt - d0, 1);
        check("l2_eng_starts", a_start_cnt - s0, 4);
`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
        check("l2_perf_stall", a_perf_stall, 5);
`endif

        // Reset during WAIT_LO of row 1, then a full layer
        d0 = a_done_cnt; s0 = a_start_cnt; w0 = a_wr_cnt;
        start_a({16'd1, 16'd1}, 1'b1);
        n = 0;
        while (a_start_cnt < s0 + 2 && n < 200) begin step(1); n++; end
        check("l3_reach_row1", a_start_cnt - s0, 2);
        reset_n = 1'b0;
        exp_q.delete(); fetch_q.delete();
        step(1);
        check_zero_a("midrst");
        reset_n = 1'b1;
        step(20);
        check("l3_no_done", a_done_cnt - d0, 0);
        check("l3_one_write", a_wr_cnt - w0, 1);

        d0 = a_done_cnt; s0 = a_start_cnt; w0 = a_wr_cnt;
        start_a({16'd2, 16'd5}, 1'b1);
        wait_done(1'b0, d0, 300);
        step(3);
        check("l4_done_once", a_done_cnt - d0, 1);
        check("l4_writes", a_wr_cnt - w0, 4);
        check("l4_eng_starts", a_start_cnt - s0, 4);

        // Single-row layer, slow engine: busy spans 18 cycles
        d0 = b_done_cnt; s0 = b_start_cnt; w0 = b_wr_cnt; b0 = b_busy_cyc;
        b_if.start = 1'b1; b_if.in_vec = {16'd1, 16'd2};
        step(1);
        b_if.start = 1'b0;
        wait_done(1'b1, d0, 200);
        step(3);
        check("b_done_once", b_done_cnt - d0, 1);
        check("b_eng_starts", b_start_cnt - s0, 1);
        check("b_writes", b_wr_cnt - w0, 1);
        check("b_wr", b_last_wr, {8'h00, 16'd16});
        check("b_busy_cycles", b_busy_cyc - b0, 18);
        check("b_busy_after", b_if.busy, 0);
`ifdef MAC_LAYER_SCHED_PERF_CNT_EN
        check("b_perf_cycles", b_perf_cycles, b_busy_cyc - b0);
        step(5);
        check("b_perf_frozen", b_perf_cycles, b_busy_cyc - b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
